// File: rtl/control_fsm_if.sv
// ============================================================================
// Module      : control_fsm_if
// Description : Bundles the decode/status/memory inputs and the datapath
//               control outputs exchanged between control_fsm and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface control_fsm_if;
    logic [31:0] instr;
    logic [4:0]  status;
    logic        mem_ready;

    logic        pcsrc;
    logic        alusrc;
    logic [3:0]  aluop;
    logic        mrw;
    logic        wb;
    logic        regrw;
    logic [1:0]  immgen_ctrl;
    logic        pc_we;
    logic        ir_we;
    logic        retire;
    logic        illegal;

    // The controller sits on the master side and drives the control bundle.
    modport master (
        input  instr, status, mem_ready,
        output pcsrc, alusrc, aluop, mrw, wb, regrw, immgen_ctrl,
               pc_we, ir_we, retire, illegal
    );

    modport slave (
        output instr, status, mem_ready,
        input  pcsrc, alusrc, aluop, mrw, wb, regrw, immgen_ctrl,
               pc_we, ir_we, retire, illegal
    );
endinterface

`default_nettype wire

// File: rtl/control_fsm.sv
// ============================================================================
// Module      : control_fsm
// Description : Multi-cycle RV32I-subset control unit (R, I-ALU, LW, SW, BR).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_fsm (
    input  wire logic      clk,
    input  wire logic      reset,
    control_fsm_if.master  bus
);

    localparam logic [3:0] c_ADD  = 4'b0000;
    localparam logic [3:0] c_SUB  = 4'b0001;
    localparam logic [3:0] c_AND  = 4'b0010;
    localparam logic [3:0] c_OR   = 4'b0011;
    localparam logic [3:0] c_XOR  = 4'b0100;
    localparam logic [3:0] c_SLL  = 4'b0101;
    localparam logic [3:0] c_SRL  = 4'b0110;
    localparam logic [3:0] c_SRA  = 4'b0111;
    localparam logic [3:0] c_SLT  = 4'b1000;
    localparam logic [3:0] c_SLTU = 4'b1001;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t r_state;
    logic   r_illegal;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br;
    logic       w_legal;
    logic       w_taken;
    logic       w_unused;

    assign w_opcode = bus.instr[6:0];
    assign w_funct3 = bus.instr[14:12];
    assign w_funct7 = bus.instr[31:25];
    assign w_unused = ^{bus.instr[24:15], bus.instr[11:7], bus.status[3], bus.status[1]};

    assign w_is_r  = (w_opcode == 7'b0110011);
    assign w_is_i  = (w_opcode == 7'b0010011);
    assign w_is_lw = (w_opcode == 7'b0000011);
    assign w_is_sw = (w_opcode == 7'b0100011);
    assign w_is_br = (w_opcode == 7'b1100011);

    always_comb begin
        w_legal = 1'b0;
        if (w_is_r) begin
            w_legal = (w_funct7 == 7'b0000000) ||
                      ((w_funct7 == 7'b0100000) &&
                       ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
        end else if (w_is_i) begin
            w_legal = 1'b1;
        end else if (w_is_lw || w_is_sw) begin
            w_legal = (w_funct3 == 3'b010);
        end else if (w_is_br) begin
            w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
        end
    end

    always_comb begin
        case (w_funct3)
            3'b000:  w_taken =  bus.status[0];
            3'b001:  w_taken = ~bus.status[0];
            3'b100:  w_taken =  bus.status[4];
            3'b101:  w_taken = ~bus.status[4];
            3'b110:  w_taken =  bus.status[2];
            3'b111:  w_taken = ~bus.status[2];
            default: w_taken = 1'b0;
        endcase
    end

    // ALU controls set up in EXEC and held unchanged through MEM and WB.
    logic       w_alusrc;
    logic [3:0] w_aluop;
    logic [1:0] w_imm;
    logic       w_alt;

    always_comb begin
        w_alusrc = ~(w_is_r | w_is_br);
        w_imm    = w_is_sw ? 2'b01 : (w_is_br ? 2'b10 : 2'b00);
        w_alt    = w_funct7[5];
        w_aluop  = c_ADD;
        if (w_is_br) begin
            w_aluop = c_SUB;
        end else if (w_is_r || w_is_i) begin
            case (w_funct3)
                3'b000:  w_aluop = (w_is_r && w_alt) ? c_SUB : c_ADD;
                3'b111:  w_aluop = c_AND;
                3'b110:  w_aluop = c_OR;
                3'b100:  w_aluop = c_XOR;
                3'b001:  w_aluop = c_SLL;
                3'b101:  w_aluop = w_alt ? c_SRA : c_SRL;
                3'b010:  w_aluop = c_SLT;
                default: w_aluop = c_SLTU;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:  if (bus.mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    if (w_legal) begin
                        r_state <= S_EXEC;
                    end else begin
                        r_state   <= S_HALT;
                        r_illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (w_is_br)                 r_state <= S_FETCH;
                    else if (w_is_lw || w_is_sw) r_state <= S_MEM;
                    else                         r_state <= S_WB;
                end
                S_MEM: begin
                    if (bus.mem_ready) r_state <= w_is_lw ? S_WB : S_FETCH;
                end
                S_WB:     r_state <= S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    logic       w_pcsrc, w_alusrc_o, w_mrw, w_wb, w_regrw;
    logic       w_pc_we, w_ir_we, w_retire, w_illegal;
    logic [3:0] w_aluop_o;
    logic [1:0] w_imm_o;

    // Reset masks every output combinationally, whatever the state holds.
    always_comb begin
        w_pcsrc    = 1'b0;
        w_alusrc_o = 1'b0;
        w_aluop_o  = 4'b0000;
        w_mrw      = 1'b0;
        w_wb       = 1'b0;
        w_regrw    = 1'b0;
        w_imm_o    = 2'b00;
        w_pc_we    = 1'b0;
        w_ir_we    = 1'b0;
        w_retire   = 1'b0;
        w_illegal  = 1'b0;
        if (!reset) begin
            w_illegal = r_illegal;
            case (r_state)
                S_FETCH: w_ir_we = bus.mem_ready;
                S_EXEC, S_MEM, S_WB: begin
                    w_alusrc_o = w_alusrc;
                    w_aluop_o  = w_aluop;
                    w_imm_o    = w_imm;
                    if (r_state == S_EXEC && w_is_br) begin
                        w_pcsrc  = w_taken;
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                    end
                    if (r_state == S_MEM && w_is_sw) begin
                        w_mrw    = 1'b1;
                        w_pc_we  = bus.mem_ready;
                        w_retire = bus.mem_ready;
                    end
                    if (r_state == S_WB) begin
                        w_regrw  = 1'b1;
                        w_wb     = w_is_lw;
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pcsrc       = w_pcsrc;
    assign bus.alusrc      = w_alusrc_o;
    assign bus.aluop       = w_aluop_o;
    assign bus.mrw         = w_mrw;
    assign bus.wb          = w_wb;
    assign bus.regrw       = w_regrw;
    assign bus.immgen_ctrl = w_imm_o;
    assign bus.pc_we       = w_pc_we;
    assign bus.ir_we       = w_ir_we;
    assign bus.retire      = w_retire;
    assign bus.illegal     = w_illegal;

endmodule

`default_nettype wire
